io_bus_arbiter: RTL



---
 rtl/io_bus_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master round-robin arbiter for the processor I/O bus.
// Master 0 is the processor I/O port, master 1 the debug/loader agent. One
// access runs at a time through a registered slave handshake. A slave that
// never answers is cut off after TIMEOUT_CYCLES and the access ends with err.
//
// Handshake: a master raises req with addr/write/wdata stable and holds it
// until its one-cycle ack. On the slave side s_valid rises with s_addr,
// s_write and s_wdata stable and stays high until the first cycle in which
// s_ready is sampled high (or the timeout expires); s_rdata is only looked
// at in a cycle where s_ready is high.
module io_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // master 0: processor I/O port
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_write,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  // master 1: debug/loader agent
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_write,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  // slave side
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic        s_write,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  // status
  output logic        busy,
  output logic        owner,
  output logic [1:0]  dbg_state
);

  // Counter just wide enough to hold TIMEOUT_CYCLES; it stops at the last
  // wait value, so it never wraps.
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          s_valid_q, s_valid_d;
  logic [31:0]   s_addr_q, s_addr_d;
  logic          s_write_q, s_write_d;
  logic [31:0]   s_wdata_q, s_wdata_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic          m0_err_q, m0_err_d;
  logic          m1_err_q, m1_err_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // Helper decodes used by the next-state logic.
  logic          grant;
  logic          finish;
  logic          timed_out;
  logic [31:0]   rd_value;

  // State and output registers; reset drops any access in flight silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      s_valid_q    <= 1'b0;
      s_addr_q     <= 32'h0;
      s_write_q    <= 1'b0;
      s_wdata_q    <= 32'h0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= 32'h0;
      m1_rdata_q   <= 32'h0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // master 0 wins the first tie
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_valid_q    <= s_valid_d;
      s_addr_q     <= s_addr_d;
      s_write_q    <= s_write_d;
      s_wdata_q    <= s_wdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and next-output logic: arbitration in IDLE, wait/timeout in
  // ACCESS, one dead cycle in DONE so the served master can drop req.
  always_comb begin
    state_d      = state_q;
    s_valid_d    = s_valid_q;
    s_addr_d     = s_addr_q;
    s_write_d    = s_write_q;
    s_wdata_d    = s_wdata_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;

    // A tie goes to the master that was not served last.
    grant     = (m0_req && m1_req) ? ~last_grant_q : m1_req;
    // s_ready wins over a timeout landing in the same cycle.
    finish    = s_ready || (cnt_q == CNT_LAST);
    timed_out = !s_ready;
    rd_value  = s_ready ? s_rdata : 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d   = grant;
          s_addr_d  = grant ? m1_addr : m0_addr;
          s_write_d = grant ? m1_write : m0_write;
          s_wdata_d = grant ? m1_wdata : m0_wdata;
          s_valid_d = 1'b1;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (finish) begin
          if (owner_q) begin
            m1_ack_d = 1'b1;
            m1_err_d = timed_out;
            if (!s_write_q) m1_rdata_d = rd_value;
          end else begin
            m0_ack_d = 1'b1;
            m0_err_d = timed_out;
            if (!s_write_q) m0_rdata_d = rd_value;
          end
          s_valid_d    = 1'b0;
          last_grant_d = owner_q;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        s_valid_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign s_valid   = s_valid_q;
  assign s_addr    = s_addr_q;
  assign s_write   = s_write_q;
  assign s_wdata   = s_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign dbg_state = state_q;

endmodule
